// File: rtl/cpu_addr_alu_seq_if.sv
// Request / response / shared-ALU signal bundle for the 16-bit address sequencer.
// The ALU opcode type is shared with the ALU input mux, so it lives in a small package here.
package cpu_alu_pkg;
    typedef enum logic [1:0] {
        ALUOP_HOLD = 2'd0,
        ALUOP_ADD  = 2'd1
    } ctrl_alu_op_t;
endpackage

interface cpu_addr_alu_seq_if;
    import cpu_alu_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [15:0]        req_base;
    logic [7:0]         req_off;
    ctrl_alu_op_t       alu_op;
    logic [7:0]         alu_src1;
    logic [7:0]         alu_src2;
    logic               alu_src2_inv;
    logic               alu_c_in;
    logic               alu_busy;
    logic [7:0]         alu_out;
    logic               alu_c_out;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [15:0]        rsp_result;
    logic               rsp_page_cross;

    // master: requester side plus the ALU that answers the sequencer's operands
    modport master (
        output req_valid, req_op, req_base, req_off, rsp_ready, alu_out, alu_c_out,
        input  req_ready, alu_op, alu_src1, alu_src2, alu_src2_inv, alu_c_in, alu_busy,
               rsp_valid, rsp_result, rsp_page_cross
    );

    modport slave (
        input  req_valid, req_op, req_base, req_off, rsp_ready, alu_out, alu_c_out,
        output req_ready, alu_op, alu_src1, alu_src2, alu_src2_inv, alu_c_in, alu_busy,
               rsp_valid, rsp_result, rsp_page_cross
    );
endinterface

// File: rtl/cpu_addr_alu_seq.sv
// Multi-cycle 16-bit address arithmetic on the shared 8-bit ALU: low byte, optional high
// byte, then a held response. High-byte cycle is skipped when no page cross occurs.
module cpu_addr_alu_seq
    import cpu_alu_pkg::*;
#(
    parameter bit SKIP_NO_CROSS = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    cpu_addr_alu_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD_IDX = 2'd0;
    localparam logic [1:0] OP_ADD_REL = 2'd1;
    localparam logic [1:0] OP_INC16   = 2'd2;
    localparam logic [1:0] OP_DEC16   = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] base_q, base_d;
    logic [7:0]  off_q, off_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic        cy_q, cy_d;
    logic        cross_q, cross_d;
    logic        hinv;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= 2'd0;
            base_q  <= 16'h0000;
            off_q   <= 8'h00;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
            cy_q    <= 1'b0;
            cross_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            base_q  <= base_d;
            off_q   <= off_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cy_q    <= cy_d;
            cross_q <= cross_d;
        end
    end

    // Decrements and negative branch offsets add 0xFF to the high byte, so a missing
    // carry (rather than a present one) is what signals the page change.
    assign hinv = (op_q == OP_DEC16) || ((op_q == OP_ADD_REL) && off_q[7]);

    always_comb begin
        state_d             = state_q;
        op_d                = op_q;
        base_d              = base_q;
        off_d               = off_q;
        lo_d                = lo_q;
        hi_d                = hi_q;
        cy_d                = cy_q;
        cross_d             = cross_q;
        bus.req_ready       = 1'b0;
        bus.rsp_valid       = 1'b0;
        bus.rsp_result      = 16'h0000;
        bus.rsp_page_cross  = 1'b0;
        bus.alu_op          = ALUOP_HOLD;
        bus.alu_src1        = 8'h00;
        bus.alu_src2        = 8'h00;
        bus.alu_src2_inv    = 1'b0;
        bus.alu_c_in        = 1'b0;
        bus.alu_busy        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    base_d  = bus.req_base;
                    off_d   = bus.req_off;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                bus.alu_busy = 1'b1;
                bus.alu_op   = ALUOP_ADD;
                bus.alu_src1 = base_q[7:0];
                case (op_q)
                    OP_ADD_IDX, OP_ADD_REL: bus.alu_src2     = off_q;
                    OP_INC16:               bus.alu_c_in     = 1'b1;
                    OP_DEC16:               bus.alu_src2_inv = 1'b1;
                    default:                bus.alu_src2     = 8'h00;
                endcase
                lo_d    = bus.alu_out;
                cy_d    = bus.alu_c_out;
                cross_d = bus.alu_c_out ^ hinv;
                if (SKIP_NO_CROSS && !cross_d) begin
                    hi_d    = base_q[15:8];
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                bus.alu_busy     = 1'b1;
                bus.alu_op       = ALUOP_ADD;
                bus.alu_src1     = base_q[15:8];
                bus.alu_src2_inv = hinv;
                bus.alu_c_in     = cy_q;
                hi_d             = bus.alu_out;
                state_d          = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid      = 1'b1;
                bus.rsp_result     = {hi_q, lo_q};
                bus.rsp_page_cross = cross_q;
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_addr_alu_seq.sv
// Bench for cpu_addr_alu_seq: two instances (skip enabled / disabled) share requests and are
// checked against a plain 16-bit arithmetic model; an 8-bit adder model plays the ALU.
module tb_cpu_addr_alu_seq;
    import cpu_alu_pkg::*;

    logic clk;
    logic rst_n;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [15:0] req_base;
    logic [7:0]  req_off;
    logic        rsp_ready;

    int n_checks;
    int n_errors;

    cpu_addr_alu_seq_if bus_a ();
    cpu_addr_alu_seq_if bus_b ();

    assign bus_a.req_valid = req_valid;
    assign bus_a.req_op    = req_op;
    assign bus_a.req_base  = req_base;
    assign bus_a.req_off   = req_off;
    assign bus_a.rsp_ready = rsp_ready;
    assign bus_b.req_valid = req_valid;
    assign bus_b.req_op    = req_op;
    assign bus_b.req_base  = req_base;
    assign bus_b.req_off   = req_off;
    assign bus_b.rsp_ready = rsp_ready;

    logic [8:0] sum_a, sum_b;
    assign sum_a = {1'b0, bus_a.alu_src1} + {1'b0, (bus_a.alu_src2_inv ? ~bus_a.alu_src2 : bus_a.alu_src2)} + {8'h00, bus_a.alu_c_in};
    assign sum_b = {1'b0, bus_b.alu_src1} + {1'b0, (bus_b.alu_src2_inv ? ~bus_b.alu_src2 : bus_b.alu_src2)} + {8'h00, bus_b.alu_c_in};
    assign bus_a.alu_out   = sum_a[7:0];
    assign bus_a.alu_c_out = sum_a[8];
    assign bus_b.alu_out   = sum_b[7:0];
    assign bus_b.alu_c_out = sum_b[8];

    // {busy, op, src1, src2, inv, c_in}
    logic [20:0] snap_a;
    assign snap_a = {bus_a.alu_busy, bus_a.alu_op, bus_a.alu_src1, bus_a.alu_src2, bus_a.alu_src2_inv, bus_a.alu_c_in};

    cpu_addr_alu_seq #(.SKIP_NO_CROSS(1'b1)) dut_a (.clock(clk), .reset_n(rst_n), .bus(bus_a.slave));
    cpu_addr_alu_seq #(.SKIP_NO_CROSS(1'b0)) dut_b (.clock(clk), .reset_n(rst_n), .bus(bus_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0]  D_OP   [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    localparam logic [15:0] D_BASE [10] = '{16'h12F0, 16'h1234, 16'h1005, 16'h1080, 16'h10F0,
                                           16'hFFFF, 16'h1234, 16'h0100, 16'h0101, 16'h0000};
    localparam logic [7:0]  D_OFF  [10] = '{8'h20, 8'h10, 8'hF0, 8'hFE, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [15:0] D_RES  [10] = '{16'h1310, 16'h1244, 16'h0FF5, 16'h107E, 16'h1110,
                                           16'h0000, 16'h1235, 16'h00FF, 16'h0100, 16'hFFFF};
    localparam logic        D_CR   [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reference: the address arithmetic itself, page cross = high byte changed.
    function automatic void ref_calc(input logic [1:0] op, input logic [15:0] base, input logic [7:0] off,
                                     output logic [15:0] res, output logic cr);
        int s;
        s = $signed(off);
        case (op)
            2'd0:    res = base + {8'h00, off};
            2'd1:    res = base + s[15:0];
            2'd2:    res = base + 16'd1;
            default: res = base - 16'd1;
        endcase
        cr = (res[15:8] != base[15:8]);
    endfunction

    // Issues one request to both instances (rsp_ready high) and collects each one's first response.
    task automatic do_req(input logic [1:0] op, input logic [15:0] base, input logic [7:0] off,
                          output int lat_a, output logic [15:0] res_a, output logic cr_a,
                          output int lat_b, output logic [15:0] res_b, output logic cr_b,
                          output logic [20:0] snap1, output logic [20:0] snap2);
        lat_a = -1; lat_b = -1;
        res_a = 16'h0; cr_a = 1'b0; res_b = 16'h0; cr_b = 1'b0;
        snap1 = 21'h0; snap2 = 21'h0;
        req_op = op; req_base = base; req_off = off; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 12 && (lat_a < 0 || lat_b < 0); c++) begin
            if (c == 1) snap1 = snap_a;
            if (c == 2) snap2 = snap_a;
            if (lat_a < 0 && bus_a.rsp_valid) begin
                lat_a = c; res_a = bus_a.rsp_result; cr_a = bus_a.rsp_page_cross;
            end
            if (lat_b < 0 && bus_b.rsp_valid) begin
                lat_b = c; res_b = bus_b.rsp_result; cr_b = bus_b.rsp_page_cross;
            end
            if (lat_a < 0 || lat_b < 0) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        $display("txn op=%0d base=%h off=%h -> a=%h cross=%0d lat=%0d | b=%h cross=%0d lat=%0d",
                 op, base, off, res_a, cr_a, lat_a, res_b, cr_b, lat_b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus_a.req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready got=%b exp=1", bus_a.req_ready); end
        n_checks++; if (bus_a.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus_a.rsp_valid); end
        n_checks++; if (bus_a.alu_busy !== 1'b0) begin n_errors++; $display("FAIL reset_alu_busy got=%b exp=0", bus_a.alu_busy); end
        n_checks++; if (bus_a.alu_op !== ALUOP_HOLD) begin n_errors++; $display("FAIL reset_alu_op got=%0d exp=%0d", bus_a.alu_op, ALUOP_HOLD); end
        n_checks++; if (bus_a.rsp_result !== 16'h0000) begin n_errors++; $display("FAIL reset_rsp_result got=%h exp=0000", bus_a.rsp_result); end
        n_checks++; if (bus_a.rsp_page_cross !== 1'b0) begin n_errors++; $display("FAIL reset_page_cross got=%b exp=0", bus_a.rsp_page_cross); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus_a.req_ready !== 1'b1 || bus_b.req_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_ready got=%b%b exp=11", bus_a.req_ready, bus_b.req_ready); end
    endtask

    task automatic test_directed();
        int la, lb; logic [15:0] ra, rb; logic ca, cb; logic [20:0] s1, s2;
        for (int i = 0; i < 10; i++) begin
            do_req(D_OP[i], D_BASE[i], D_OFF[i], la, ra, ca, lb, rb, cb, s1, s2);
            n_checks++; if (ra !== D_RES[i]) begin n_errors++; $display("FAIL dir%0d_result_skip got=%h exp=%h", i, ra, D_RES[i]); end
            n_checks++; if (ca !== D_CR[i]) begin n_errors++; $display("FAIL dir%0d_cross_skip got=%b exp=%b", i, ca, D_CR[i]); end
            n_checks++; if (la != (D_CR[i] ? 3 : 2)) begin n_errors++; $display("FAIL dir%0d_latency_skip got=%0d exp=%0d", i, la, (D_CR[i] ? 3 : 2)); end
            n_checks++; if (rb !== D_RES[i]) begin n_errors++; $display("FAIL dir%0d_result_noskip got=%h exp=%h", i, rb, D_RES[i]); end
            n_checks++; if (cb !== D_CR[i]) begin n_errors++; $display("FAIL dir%0d_cross_noskip got=%b exp=%b", i, cb, D_CR[i]); end
            n_checks++; if (lb != 3) begin n_errors++; $display("FAIL dir%0d_latency_noskip got=%0d exp=3", i, lb); end
            if (i == 0) begin
                n_checks++; if (s1 !== {1'b1, ALUOP_ADD, 8'hF0, 8'h20, 1'b0, 1'b0}) begin n_errors++; $display("FAIL idx_lo_alu got=%h exp=%h", s1, {1'b1, ALUOP_ADD, 8'hF0, 8'h20, 1'b0, 1'b0}); end
                n_checks++; if (s2 !== {1'b1, ALUOP_ADD, 8'h12, 8'h00, 1'b0, 1'b1}) begin n_errors++; $display("FAIL idx_hi_alu got=%h exp=%h", s2, {1'b1, ALUOP_ADD, 8'h12, 8'h00, 1'b0, 1'b1}); end
            end
            if (i == 1) begin
                n_checks++; if (s2[20:18] !== {1'b0, ALUOP_HOLD}) begin n_errors++; $display("FAIL skip_cycle2_hold got=%h exp=%h", s2[20:18], {1'b0, ALUOP_HOLD}); end
            end
            if (i == 2) begin
                n_checks++; if (s2[1] !== 1'b1) begin n_errors++; $display("FAIL rel_hi_inv got=%b exp=1", s2[1]); end
            end
            if (i == 9) begin
                n_checks++; if (s1 !== {1'b1, ALUOP_ADD, 8'h00, 8'h00, 1'b1, 1'b0}) begin n_errors++; $display("FAIL dec_lo_alu got=%h exp=%h", s1, {1'b1, ALUOP_ADD, 8'h00, 8'h00, 1'b1, 1'b0}); end
            end
        end
    endtask

    task automatic test_random();
        int la, lb; logic [15:0] ra, rb, er; logic ca, cb, ec; logic [20:0] s1, s2;
        logic [1:0] op; logic [15:0] base; logic [7:0] off;
        for (int i = 0; i < 60; i++) begin
            op   = 2'($urandom_range(0, 3));
            base = 16'($urandom);
            off  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) base[7:0] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            ref_calc(op, base, off, er, ec);
            do_req(op, base, off, la, ra, ca, lb, rb, cb, s1, s2);
            n_checks++; if (ra !== er) begin n_errors++; $display("FAIL rnd%0d_result_skip got=%h exp=%h", i, ra, er); end
            n_checks++; if (ca !== ec) begin n_errors++; $display("FAIL rnd%0d_cross_skip got=%b exp=%b", i, ca, ec); end
            n_checks++; if (la != (ec ? 3 : 2)) begin n_errors++; $display("FAIL rnd%0d_latency_skip got=%0d exp=%0d", i, la, (ec ? 3 : 2)); end
            n_checks++; if (rb !== er) begin n_errors++; $display("FAIL rnd%0d_result_noskip got=%h exp=%h", i, rb, er); end
            n_checks++; if (cb !== ec) begin n_errors++; $display("FAIL rnd%0d_cross_noskip got=%b exp=%b", i, cb, ec); end
            n_checks++; if (lb != 3) begin n_errors++; $display("FAIL rnd%0d_latency_noskip got=%0d exp=3", i, lb); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] er; logic ec; bit seen;
        ref_calc(2'd0, 16'h12F0, 8'h20, er, ec);
        rsp_ready = 1'b0;
        req_op = 2'd0; req_base = 16'h12F0; req_off = 8'h20; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (bus_a.rsp_valid) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (!seen) begin n_errors++; $display("FAIL bp_rsp_timeout got=0 exp=1"); end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (bus_a.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL bp%0d_rsp_valid got=%b exp=1", k, bus_a.rsp_valid); end
            n_checks++; if (bus_a.rsp_result !== er) begin n_errors++; $display("FAIL bp%0d_result got=%h exp=%h", k, bus_a.rsp_result, er); end
            n_checks++; if (bus_a.rsp_page_cross !== ec) begin n_errors++; $display("FAIL bp%0d_cross got=%b exp=%b", k, bus_a.rsp_page_cross, ec); end
            n_checks++; if (bus_a.req_ready !== 1'b0) begin n_errors++; $display("FAIL bp%0d_req_ready got=%b exp=0", k, bus_a.req_ready); end
            n_checks++; if (bus_a.alu_busy !== 1'b0) begin n_errors++; $display("FAIL bp%0d_alu_busy got=%b exp=0", k, bus_a.alu_busy); end
            if (k == 2) begin
                req_op = 2'd2; req_base = 16'hABCD; req_valid = 1'b1;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus_a.req_ready !== 1'b1 || bus_a.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL bp_release got=%b%b exp=10", bus_a.req_ready, bus_a.rsp_valid); end
        @(posedge clk); #1;
        n_checks++; if (bus_a.req_ready !== 1'b1 || bus_a.alu_busy !== 1'b0) begin n_errors++; $display("FAIL bp_pulse_ignored got=%b%b exp=10", bus_a.req_ready, bus_a.alu_busy); end
        $display("txn backpressure base=12F0 off=20 result=%h cross=%0d", er, ec);
    endtask

    task automatic test_back_to_back();
        int acc_a, acc_b, n_rsp;
        acc_a = 0; acc_b = 0; n_rsp = 0;
        req_op = 2'd2; req_base = 16'h1234; req_off = 8'h00; req_valid = 1'b1;
        for (int s = 0; s < 12; s++) begin
            if (bus_a.req_ready) acc_a++;
            if (bus_b.req_ready) acc_b++;
            if (bus_a.rsp_valid) begin
                n_rsp++;
                n_checks++; if (bus_a.rsp_result !== 16'h1235) begin n_errors++; $display("FAIL b2b_result got=%h exp=1235", bus_a.rsp_result); end
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        n_checks++; if (acc_a != 4) begin n_errors++; $display("FAIL b2b_accepts_skip got=%0d exp=4", acc_a); end
        n_checks++; if (acc_b != 3) begin n_errors++; $display("FAIL b2b_accepts_noskip got=%0d exp=3", acc_b); end
        n_checks++; if (n_rsp != 4) begin n_errors++; $display("FAIL b2b_responses got=%0d exp=4", n_rsp); end
        for (int c = 0; c < 6 && !(bus_a.req_ready && bus_b.req_ready); c++) begin
            @(posedge clk); #1;
        end
        n_checks++; if (!(bus_a.req_ready && bus_b.req_ready)) begin n_errors++; $display("FAIL b2b_drain got=%b%b exp=11", bus_a.req_ready, bus_b.req_ready); end
        $display("txn back_to_back accepts skip=%0d noskip=%0d responses=%0d", acc_a, acc_b, n_rsp);
    endtask

    task automatic test_reset_mid();
        int la, lb; logic [15:0] ra, rb; logic ca, cb; logic [20:0] s1, s2;
        rsp_ready = 1'b1;
        req_op = 2'd0; req_base = 16'h12F0; req_off = 8'h20; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus_a.alu_busy !== 1'b1 || bus_a.alu_src1 !== 8'h12) begin n_errors++; $display("FAIL rstmid_in_hi got=%b/%h exp=1/12", bus_a.alu_busy, bus_a.alu_src1); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus_a.req_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_req_ready got=%b exp=1", bus_a.req_ready); end
        n_checks++; if (bus_a.alu_busy !== 1'b0 || bus_a.alu_op !== ALUOP_HOLD) begin n_errors++; $display("FAIL rstmid_alu got=%b/%0d exp=0/0", bus_a.alu_busy, bus_a.alu_op); end
        n_checks++; if (bus_a.rsp_valid !== 1'b0 || bus_a.rsp_result !== 16'h0000) begin n_errors++; $display("FAIL rstmid_rsp got=%b/%h exp=0/0000", bus_a.rsp_valid, bus_a.rsp_result); end
        @(posedge clk); #1;
        n_checks++; if (bus_a.rsp_valid !== 1'b0 || bus_b.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_rsp got=%b%b exp=00", bus_a.rsp_valid, bus_b.rsp_valid); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus_a.req_ready !== 1'b1 || bus_a.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_after got=%b%b exp=10", bus_a.req_ready, bus_a.rsp_valid); end
        do_req(2'd3, 16'h0100, 8'h00, la, ra, ca, lb, rb, cb, s1, s2);
        n_checks++; if (ra !== 16'h00FF || ca !== 1'b1) begin n_errors++; $display("FAIL rstmid_new_req got=%h/%b exp=00FF/1", ra, ca); end
        n_checks++; if (la != 3 || lb != 3) begin n_errors++; $display("FAIL rstmid_new_lat got=%0d/%0d exp=3/3", la, lb); end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_base = 16'h0; req_off = 8'h0; rsp_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
